mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single-ported RAM between the icache fill path (iREN/iaddr) and the dcache fill/writeback path (dREN/dWEN/daddr/dstore) that sit under the caches block.
- Default priority is dcache. A starvation counter forces an icache grant after STARVE_MAX back-to-back dcache grants that occur while the icache is waiting.
- Generates the per-requester wait signals and steers RAM read data back to each requester.

Parameters:
- ADDR_W, 32, address width for iaddr, daddr and ram_addr.
- DATA_W, 32, data width for dstore, ram_store, ram_load, iload and dload.
- STARVE_MAX, 4, number of consecutive dcache grants allowed while iREN is pending (legal range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache address.
- iwait  out  1  low for exactly one cycle when the icache access completes.
- iload  out  DATA_W  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly one cycle when the dcache access completes.
- dload  out  DATA_W  dcache read data.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data, valid while ram_ready is high.
- ram_ready  in  1  RAM access-complete pulse.

Behaviour:
- State machine states: IDLE, DGRANT, IGRANT. The state register and starve_cnt are registered; all outputs are decoded combinationally from the state.
- Reset (asynchronous, nRST low):
  - state=IDLE, starve_cnt=0.
  - Outputs while in reset: iwait=1, dwait=1, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, iload=0, dload=0.
- Reset asserted mid-grant: the FSM drops to IDLE immediately and all RAM strobes fall in the same cycle. The interrupted access is lost; there is no completion pulse.
- IDLE transitions:
  - (dREN|dWEN) && !(iREN && starve_cnt==STARVE_MAX) -> DGRANT.
  - else iREN -> IGRANT.
  - else stay in IDLE.
- IDLE outputs: strobes 0, ram_addr=0, ram_store=0, both waits 1.
- DGRANT outputs:
  - ram_addr=daddr, ram_store=dstore, ram_wen=dWEN, ram_ren=dREN&!dWEN (write wins if both are high).
  - dwait=!ram_ready; dload=ram_load when ram_ready is high, else 0.
- IGRANT outputs:
  - ram_addr=iaddr, ram_ren=1, ram_wen=0, ram_store=0.
  - iwait=!ram_ready; iload=ram_load when ram_ready is high, else 0.
- Grant exits:
  - DGRANT/IGRANT with ram_ready=1 -> IDLE. This always inserts one IDLE turnaround cycle between grants.
  - Owner drops its request before ram_ready (dREN=dWEN=0 in DGRANT, iREN=0 in IGRANT) -> IDLE. Strobes fall in that cycle and no wait pulse is produced.
- Latency: request seen in IDLE at cycle 0 -> strobes asserted in cycle 1 -> wait low in the same cycle as ram_ready -> IDLE in the following cycle. Minimum access is 2 cycles.
- starve_cnt updates:
  - DGRANT completes with iREN=1 -> saturating +1 (never exceeds STARVE_MAX).
  - DGRANT completes with iREN=0 -> 0.
  - IGRANT completes -> 0.
  - Aborted grant -> unchanged.
- The non-owner's wait output stays 1 throughout any grant.
- ram_ready arriving in IDLE is ignored: no state change, both waits stay 1.

Test Plan:
- Reset mid-operation: drive nRST=0 during DGRANT with ram_wen=1 -> ram_wen=0 and dwait=1 in the same cycle; after release, state=IDLE and all outputs are at their reset values.
- Lone icache read: iREN=1, iaddr=0x100, ram_ready pulses 3 cycles after the grant with ram_load=0xDEADBEEF -> iwait=0 for one cycle with iload=0xDEADBEEF, then iwait=1; dwait=1 throughout.
- Simultaneous requests: iREN=1 and dWEN=1 at daddr=0x200, dstore=0x12345678 -> dcache is granted first with ram_wen=1, ram_addr=0x200; after dwait pulses, IDLE for one cycle, then IGRANT.
- Starvation: iREN held high with dREN reissued every turnaround, STARVE_MAX=4 -> exactly 4 dcache completions, then an IGRANT with iwait pulse, then starve_cnt=0 and dcache is granted again.
- Request withdrawn: dREN deasserted in DGRANT before ram_ready -> IDLE next cycle, no dwait pulse, starve_cnt unchanged, a pending iREN is granted afterward.
- Stray ready: ram_ready=1 while in IDLE with no requests -> no state change, iwait=dwait=1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache fill paths, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // icache fill path
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  // dcache fill / writeback path
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  // single-ported RAM
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iwait, iload, dwait, dload, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter for the single-ported RAM shared by the icache and dcache.
// dcache wins by default; after STARVE_MAX consecutive dcache grants that
// complete while the icache is waiting, the icache is forced in next.
// Every grant is followed by one IDLE turnaround cycle.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, next_state;
  logic [3:0]  starve_cnt, next_cnt;
  logic        d_req;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] store_mux;
  logic [DATA_W-1:0] iload_mux;
  logic [DATA_W-1:0] dload_mux;

  assign d_req = bus.dREN | bus.dWEN;

  // State and starvation counter; reset drops any grant in progress at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state      <= next_state;
      starve_cnt <= next_cnt;
    end
  end

  // Next-state and starvation counter update.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    next_state = state;
    next_cnt   = starve_cnt;
    unique case (state)
      IDLE: begin
        if (d_req && !(bus.iREN && starve_cnt == STARVE_LIM))
          next_state = DGRANT;
        else if (bus.iREN)
          next_state = IGRANT;
      end
      DGRANT: begin
        // Completion takes precedence over a same-cycle request drop.
        if (bus.ram_ready) begin
          next_state = IDLE;
          if (bus.iREN)
            next_cnt = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
          else
            next_cnt = '0;
        end else if (!d_req) begin
          next_state = IDLE;   // aborted: counter left alone
        end
      end
      IGRANT: begin
        if (bus.ram_ready) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (!bus.iREN) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the current grant; IDLE (and reset) drives everything quiet.
  always_comb begin
    addr_mux    = '0;
    store_mux   = '0;
    iload_mux   = '0;
    dload_mux   = '0;
    bus.ram_ren = 1'b0;
    bus.ram_wen = 1'b0;
    bus.iwait   = 1'b1;
    bus.dwait   = 1'b1;
    unique case (state)
      DGRANT: begin
        addr_mux    = bus.daddr;
        store_mux   = bus.dstore;
        bus.ram_wen = bus.dWEN;
        bus.ram_ren = bus.dREN & ~bus.dWEN;   // write wins over read
        bus.dwait   = ~bus.ram_ready;
        if (bus.ram_ready) dload_mux = bus.ram_load;
      end
      IGRANT: begin
        addr_mux    = bus.iaddr;
        bus.ram_ren = 1'b1;
        bus.iwait   = ~bus.ram_ready;
        if (bus.ram_ready) iload_mux = bus.ram_load;
      end
      default: ;
    endcase
  end

  assign bus.ram_addr  = addr_mux;
  assign bus.ram_store = store_mux;
  assign bus.iload     = iload_mux;
  assign bus.dload     = dload_mux;

endmodule
